// File: rtl/apb_completer_mem.sv
// apb_completer_mem: APB4 completer backed by a word-addressed register array with programmable wait states
module apb_completer_mem #(
  parameter int                    ADDR_WIDTH  = 32,
  parameter int                    DATA_WIDTH  = 32,
  parameter int                    DEPTH_LG2   = 8,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0,
  parameter int                    WAIT_CYCLES = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  psel,
  input  logic                  penable,
  input  logic                  pwrite,
  input  logic [ADDR_WIDTH-1:0] paddr,
  input  logic [DATA_WIDTH-1:0] pwdata,
  input  logic [3:0]            pstrb,
  output logic                  pready,
  output logic [DATA_WIDTH-1:0] prdata,
  output logic                  pslverr,
  output logic [7:0]            err_count
);
  localparam logic IDLE = 1'b0;
  localparam logic ACCESS = 1'b1;
  localparam int DEPTH = 1 << DEPTH_LG2;
  localparam logic [ADDR_WIDTH:0] SPAN = (ADDR_WIDTH+1)'(4) << DEPTH_LG2;
  logic                  state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [DEPTH_LG2-1:0]  idx_q, idx_d;
  logic                  wr_q, wr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] prdata_q, prdata_d;
  logic [3:0]            strb_q, strb_d;
  logic                  err_q, err_d;
  logic [7:0]            err_count_q, err_count_d;
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [ADDR_WIDTH-1:0] off;
  logic                  err_in;
  logic [DEPTH_LG2-1:0]  idx_in;
  logic                  done;
  logic                  commit;
  assign off       = paddr - BASE_ADDR;
  assign err_in    = (|paddr[1:0]) | (paddr < BASE_ADDR) | ({1'b0, off} >= SPAN);
  assign idx_in    = off[DEPTH_LG2+1:2];
  assign pready    = state_q == ACCESS && cnt_q == 4'd0;
  assign done      = pready & psel & penable;
  assign commit    = done & wr_q & ~err_q;
  assign pslverr   = pready & err_q;
  assign prdata    = prdata_q;
  assign err_count = err_count_q;
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    wr_d        = wr_q;
    wdata_d     = wdata_q;
    strb_d      = strb_q;
    err_d       = err_q;
    prdata_d    = prdata_q;
    err_count_d = (done && err_q && err_count_q != 8'hFF) ? err_count_q + 8'd1 : err_count_q;
    if (state_q == IDLE) begin
      if (psel && !penable) begin
        state_d  = ACCESS;
        cnt_d    = 4'(WAIT_CYCLES);
        idx_d    = idx_in;
        wr_d     = pwrite;
        wdata_d  = pwdata;
        strb_d   = pstrb;
        err_d    = err_in;
        prdata_d = err_in ? '0 : mem_q[idx_in];
      end
    end else if (!psel || done) begin
      state_d = IDLE;
    end else if (cnt_q != 4'd0) begin
      cnt_d = cnt_q - 4'd1;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      idx_q       <= '0;
      wr_q        <= 1'b0;
      wdata_q     <= '0;
      strb_q      <= '0;
      err_q       <= 1'b0;
      prdata_q    <= '0;
      err_count_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      wr_q        <= wr_d;
      wdata_q     <= wdata_d;
      strb_q      <= strb_d;
      err_q       <= err_d;
      prdata_q    <= prdata_d;
      err_count_q <= err_count_d;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (commit) begin
      for (int b = 0; b < 4; b++) if (strb_q[b]) mem_q[idx_q][8*b +: 8] <= wdata_q[8*b +: 8];
    end
  end
endmodule
